// File: rtl/m3_pkg.sv
// Shared types, default geometry and lookup helpers for the dequant writer.
// Pure declarations and combinational functions; no latency.
// No flow control of its own.
package m3_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PLANE_Y = 2'd0,
        PLANE_U = 2'd1,
        PLANE_V = 2'd2
    } plane_t;

    // Default image geometry: 320x240 luma, 160x240 chroma, 8x8 blocks.
    localparam logic [17:0] PRE_IDCT_BASE_DEF = 18'd76800;
    localparam logic [17:0] U_OFFSET_DEF      = 18'd76800;
    localparam logic [17:0] V_OFFSET_DEF      = 18'd115200;
    localparam int          Y_COL_BLOCKS_DEF  = 40;
    localparam int          UV_COL_BLOCKS_DEF = 20;
    localparam int          ROW_BLOCKS_DEF    = 30;

    // Zigzag position k -> {row, col}; each octal digit is one 3-bit coordinate.
    function automatic logic [5:0] zz_rc(input logic [5:0] k);
        logic [5:0] rc;
        case (k)
            6'd0:  rc = 6'o00;  6'd1:  rc = 6'o01;  6'd2:  rc = 6'o10;  6'd3:  rc = 6'o20;
            6'd4:  rc = 6'o11;  6'd5:  rc = 6'o02;  6'd6:  rc = 6'o03;  6'd7:  rc = 6'o12;
            6'd8:  rc = 6'o21;  6'd9:  rc = 6'o30;  6'd10: rc = 6'o40;  6'd11: rc = 6'o31;
            6'd12: rc = 6'o22;  6'd13: rc = 6'o13;  6'd14: rc = 6'o04;  6'd15: rc = 6'o05;
            6'd16: rc = 6'o14;  6'd17: rc = 6'o23;  6'd18: rc = 6'o32;  6'd19: rc = 6'o41;
            6'd20: rc = 6'o50;  6'd21: rc = 6'o60;  6'd22: rc = 6'o51;  6'd23: rc = 6'o42;
            6'd24: rc = 6'o33;  6'd25: rc = 6'o24;  6'd26: rc = 6'o15;  6'd27: rc = 6'o06;
            6'd28: rc = 6'o07;  6'd29: rc = 6'o16;  6'd30: rc = 6'o25;  6'd31: rc = 6'o34;
            6'd32: rc = 6'o43;  6'd33: rc = 6'o52;  6'd34: rc = 6'o61;  6'd35: rc = 6'o70;
            6'd36: rc = 6'o71;  6'd37: rc = 6'o62;  6'd38: rc = 6'o53;  6'd39: rc = 6'o44;
            6'd40: rc = 6'o35;  6'd41: rc = 6'o26;  6'd42: rc = 6'o17;  6'd43: rc = 6'o27;
            6'd44: rc = 6'o36;  6'd45: rc = 6'o45;  6'd46: rc = 6'o54;  6'd47: rc = 6'o63;
            6'd48: rc = 6'o72;  6'd49: rc = 6'o73;  6'd50: rc = 6'o64;  6'd51: rc = 6'o55;
            6'd52: rc = 6'o46;  6'd53: rc = 6'o37;  6'd54: rc = 6'o47;  6'd55: rc = 6'o56;
            6'd56: rc = 6'o65;  6'd57: rc = 6'o74;  6'd58: rc = 6'o75;  6'd59: rc = 6'o66;
            6'd60: rc = 6'o57;  6'd61: rc = 6'o67;  6'd62: rc = 6'o76;  6'd63: rc = 6'o77;
            default: rc = 6'o00;
        endcase
        return rc;
    endfunction

    function automatic logic [2:0] zz_row(input logic [5:0] k);
        logic [5:0] rc;
        rc = zz_rc(k);
        return rc[5:3];
    endfunction

    function automatic logic [2:0] zz_col(input logic [5:0] k);
        logic [5:0] rc;
        rc = zz_rc(k);
        return rc[2:0];
    endfunction

    // Q0 left-shift amount by frequency band r+c.
    function automatic logic [2:0] q0_shift(input logic [3:0] band);
        case (band)
            4'd0: return 3'd3;
            4'd1: return 3'd2;
            4'd2, 4'd3: return 3'd3;
            4'd4, 4'd5: return 3'd4;
            4'd6, 4'd7: return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    // Q1 left-shift amount by frequency band r+c.
    function automatic logic [2:0] q1_shift(input logic [3:0] band);
        case (band)
            4'd0: return 3'd3;
            4'd1, 4'd2, 4'd3: return 3'd1;
            4'd4, 4'd5: return 3'd2;
            4'd6, 4'd7: return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dequant_writer_if.sv
// Quantized-coefficient stream from the lossless decoder.
// Wires only; no latency.
// Valid/ready: a beat transfers when coeff_valid and coeff_ready are both high.
interface dequant_writer_if;
    logic signed [15:0] coeff_data;
    logic               coeff_valid;
    logic               coeff_ready;

    modport master (output coeff_data, output coeff_valid, input coeff_ready);
    modport slave  (input coeff_data, input coeff_valid, output coeff_ready);
endinterface

// File: rtl/zigzag_dequant.sv
// Maps a zigzag index to raster (r,c) and dequantizes the coefficient with saturation.
// Purely combinational.
// No flow control; the caller qualifies the result with its handshake.
module zigzag_dequant
    import m3_pkg::*;
(
    input  logic [5:0]         k_i,
    input  logic signed [15:0] coeff_i,
    input  logic               q_sel_i,
    output logic [2:0]         r_o,
    output logic [2:0]         c_o,
    output logic signed [15:0] value_o
);
    logic [3:0]         band;
    logic [2:0]         shift;
    logic signed [22:0] ext;
    logic signed [22:0] wide;

    // Lookup, shift in 23 bits (no overflow possible at shift<=6), then clamp to int16.
    always_comb begin
        r_o   = zz_row(k_i);
        c_o   = zz_col(k_i);
        band  = {1'b0, r_o} + {1'b0, c_o};
        shift = q_sel_i ? q1_shift(band) : q0_shift(band);
        ext   = {{7{coeff_i[15]}}, coeff_i};
        wide  = ext <<< shift;
        if (wide > 23'sd32767) begin
            value_o = 16'sh7FFF;
        end else if (wide < -23'sd32768) begin
            value_o = 16'sh8000;
        end else begin
            value_o = wide[15:0];
        end
    end
endmodule

// File: rtl/dequant_writer.sv
// Writes dequantized, raster-ordered coefficients of a Y/U/V image into pre-IDCT SRAM.
// Latency 1: the SRAM write appears the cycle after each accepted coefficient.
// coeff_ready is high for the whole image run; the producer may stall for any length.
module dequant_writer
    import m3_pkg::*;
#(
    parameter logic [17:0] PRE_IDCT_BASE = PRE_IDCT_BASE_DEF,
    parameter logic [17:0] U_OFFSET      = U_OFFSET_DEF,
    parameter logic [17:0] V_OFFSET      = V_OFFSET_DEF,
    parameter int          Y_COL_BLOCKS  = Y_COL_BLOCKS_DEF,
    parameter int          UV_COL_BLOCKS = UV_COL_BLOCKS_DEF,
    parameter int          ROW_BLOCKS    = ROW_BLOCKS_DEF
)(
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   q_sel,
    output logic                   finish,
    dequant_writer_if.slave        cin,
    output logic [17:0]            SRAM_address,
    output logic [15:0]            SRAM_write_data,
    output logic                   SRAM_we_n
);
    localparam logic [5:0] Y_COL_LAST  = 6'(Y_COL_BLOCKS - 1);
    localparam logic [5:0] UV_COL_LAST = 6'(UV_COL_BLOCKS - 1);
    localparam logic [4:0] ROW_LAST    = 5'(ROW_BLOCKS - 1);

    state_t      state_q, state_d;
    logic [5:0]  k_q, k_d;
    logic [5:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    plane_t      plane_q, plane_d;
    logic        qsel_q, qsel_d;
    logic        we_n_q;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q;

    logic        hs, k_last, col_last, row_last, img_last;
    logic [2:0]  zr, zc;
    logic signed [15:0] deq;
    logic [7:0]  row_pix;
    logic [8:0]  col_pix;
    logic [17:0] row_base, plane_base;

    assign hs       = cin.coeff_valid & cin.coeff_ready;
    assign k_last   = (k_q == 6'd63);
    assign col_last = (col_q == ((plane_q == PLANE_Y) ? Y_COL_LAST : UV_COL_LAST));
    assign row_last = (row_q == ROW_LAST);
    assign img_last = k_last & col_last & row_last & (plane_q == PLANE_V);

    zigzag_dequant u_zz (
        .k_i     (k_q),
        .coeff_i (cin.coeff_data),
        .q_sel_i (qsel_q),
        .r_o     (zr),
        .c_o     (zc),
        .value_o (deq)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: start only counts in idle; the last beat of plane V ends the image.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (hs && img_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: accept while running, pulse finish for the single done cycle.
    always_comb begin
        cin.coeff_ready = (state_q == S_RUN);
        finish          = (state_q == S_DONE);
    end

    // Position counters: k inside the block, then block column, block row, plane.
    always_comb begin
        k_d     = k_q;
        col_d   = col_q;
        row_d   = row_q;
        plane_d = plane_q;
        qsel_d  = qsel_q;
        if (state_q == S_IDLE && start) begin
            k_d     = 6'd0;
            col_d   = 6'd0;
            row_d   = 5'd0;
            plane_d = PLANE_Y;
            qsel_d  = q_sel;
        end else if (hs) begin
            k_d = k_q + 6'd1;
            if (k_last) begin
                if (col_last) begin
                    col_d = 6'd0;
                    if (row_last) begin
                        row_d = 5'd0;
                        case (plane_q)
                            PLANE_Y: plane_d = PLANE_U;
                            PLANE_U: plane_d = PLANE_V;
                            default: plane_d = PLANE_Y;
                        endcase
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end else begin
                    col_d = col_q + 6'd1;
                end
            end
        end
    end

    // Counter and latched q_sel registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            k_q     <= 6'd0;
            col_q   <= 6'd0;
            row_q   <= 5'd0;
            plane_q <= PLANE_Y;
            qsel_q  <= 1'b0;
        end else begin
            k_q     <= k_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            qsel_q  <= qsel_d;
        end
    end

    // Address: plane base + pixel_row * width (as shift-adds) + pixel_col.
    always_comb begin
        row_pix = {row_q, zr};
        col_pix = {col_q, zc};
        if (plane_q == PLANE_Y) begin
            row_base   = ({10'd0, row_pix} << 8) + ({10'd0, row_pix} << 6);
            plane_base = PRE_IDCT_BASE;
        end else begin
            row_base   = ({10'd0, row_pix} << 7) + ({10'd0, row_pix} << 5);
            plane_base = PRE_IDCT_BASE + ((plane_q == PLANE_U) ? U_OFFSET : V_OFFSET);
        end
        addr_d = plane_base + row_base + {9'd0, col_pix};
    end

    // Registered SRAM write port; a write strobe only follows an accepted beat.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            we_n_q <= 1'b1;
            addr_q <= 18'd0;
            data_q <= 16'd0;
        end else begin
            we_n_q <= ~hs;
            if (hs) begin
                addr_q <= addr_d;
                data_q <= deq;
            end
        end
    end

    assign SRAM_we_n       = we_n_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
endmodule

// File: tb/tb_dequant_writer.sv
// Bench for dequant_writer on a reduced block grid (4x3 Y, 2x3 U/V blocks, default bases).
// Table vectors, hand sequences for reset/idle corners, and a randomized full image.
// Expected values come from an arithmetic model of the zigzag/plane/quant rules.
module tb_dequant_writer;

    localparam int YC   = 4;
    localparam int UVC  = 2;
    localparam int RB   = 3;
    localparam int NY   = YC * RB;
    localparam int NUV  = UVC * RB;
    localparam int TOTAL = (NY + 2 * NUV) * 64;
    localparam int NVEC = 19;

    logic        clock, resetn, start, q_sel, finish, SRAM_we_n;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;

    dequant_writer_if cif();

    dequant_writer #(
        .Y_COL_BLOCKS  (YC),
        .UV_COL_BLOCKS (UVC),
        .ROW_BLOCKS    (RB)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .start           (start),
        .q_sel           (q_sel),
        .finish          (finish),
        .cin             (cif),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int zr[64];
    int zc[64];
    int Q0_SH[9] = '{3, 2, 3, 3, 4, 4, 5, 5, 6};
    int Q1_SH[9] = '{3, 1, 1, 1, 2, 2, 3, 3, 4};

    typedef struct {
        bit qs;
        int n;
        int coeff;
        int exp_addr;
        int exp_data;
    } vec_t;
    vec_t vt[NVEC];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Zigzag order built by walking anti-diagonals, alternating direction.
    function automatic void build_zigzag();
        int idx, lo, hi;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zr[idx] = r; zc[idx] = s - r; idx++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zr[idx] = r; zc[idx] = s - r; idx++; end
            end
        end
    endfunction

    function automatic int exp_addr(input int n);
        int blk, k, b, bpr, off, w;
        blk = n / 64;
        k   = n % 64;
        if (blk < NY) begin
            b = blk; bpr = YC; off = 0; w = 320;
        end else if (blk < NY + NUV) begin
            b = blk - NY; bpr = UVC; off = 76800; w = 160;
        end else begin
            b = blk - NY - NUV; bpr = UVC; off = 115200; w = 160;
        end
        return 76800 + off + ((b / bpr) * 8 + zr[k]) * w + (b % bpr) * 8 + zc[k];
    endfunction

    function automatic int exp_val(input logic [15:0] d, input int k, input bit qs);
        int band, sh, v;
        band = zr[k] + zc[k];
        if (band > 8) band = 8;
        sh = qs ? Q1_SH[band] : Q0_SH[band];
        v = int'($signed(d)) * (1 << sh);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    function automatic logic [15:0] rand_coeff();
        int x;
        if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535));
        else x = int'($urandom_range(0, 127)) - 64;
        return x[15:0];
    endfunction

    task automatic cycle(input bit v, input logic [15:0] d, output bit hs);
        cif.coeff_valid = v;
        cif.coeff_data  = d;
        hs = v && cif.coeff_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input bit qs);
        bit h;
        q_sel = qs;
        start = 1'b1;
        cycle(1'b0, 16'd0, h);
        start = 1'b0;
        q_sel = ~qs;
    endtask

    task automatic restart(input bit qs);
        cif.coeff_valid = 1'b0;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        do_start(qs);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        bit h, qs, v, done;
        logic [15:0] d;
        int pos, wr_cnt, fin_cnt, n;

        build_zigzag();
        vt[0]  = '{1'b0, 0,    5,     76800,  40};
        vt[1]  = '{1'b0, 0,    1,     76800,  8};
        vt[2]  = '{1'b0, 1,    2,     76801,  8};
        vt[3]  = '{1'b0, 2,    3,     77120,  12};
        vt[4]  = '{1'b0, 5,    -4096, 76802,  -32768};
        vt[5]  = '{1'b0, 63,   1,     79047,  64};
        vt[6]  = '{1'b0, 64,   1,     76808,  8};
        vt[7]  = '{1'b0, 256,  -1,    79360,  -8};
        vt[8]  = '{1'b0, 768,  2,     153600, 16};
        vt[9]  = '{1'b0, 896,  1,     154880, 8};
        vt[10] = '{1'b0, 1152, 0,     192000, 0};
        vt[11] = '{1'b0, 1535, 1,     195695, 64};
        vt[12] = '{1'b0, 63,   4096,  79047,  32767};
        vt[13] = '{1'b0, 63,   -1000, 79047,  -32768};
        vt[14] = '{1'b0, 63,   512,   79047,  32767};
        vt[15] = '{1'b1, 0,    7,     76800,  56};
        vt[16] = '{1'b1, 1,    7,     76801,  14};
        vt[17] = '{1'b1, 4,    100,   77121,  200};
        vt[18] = '{1'b1, 63,   -3,    79047,  -48};

        resetn = 1'b0; start = 1'b0; q_sel = 1'b0;
        cif.coeff_valid = 1'b0; cif.coeff_data = 16'd0;
        @(posedge clock); @(posedge clock); #1;
        chk("rst_finish", finish, 0);
        chk("rst_ready", cif.coeff_ready, 0);
        chk("rst_we_n", SRAM_we_n, 1);
        chk("rst_addr", SRAM_address, 0);
        chk("rst_data", SRAM_write_data, 0);
        resetn = 1'b1;

        // Valid while idle must be ignored.
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 16'd123, h);
            chk("idle_we_n", SRAM_we_n, 1);
            chk("idle_ready", cif.coeff_ready, 0);
        end

        // Table vectors.
        pos = TOTAL;
        qs  = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            if (pos >= TOTAL || vt[i].n < pos || vt[i].qs != qs) begin
                restart(vt[i].qs);
                pos = 0;
                qs  = vt[i].qs;
            end
            for (int j = pos; j < vt[i].n; j++) cycle(1'b1, 16'd0, h);
            chk("tbl_ready", cif.coeff_ready, 1);
            cycle(1'b1, 16'(vt[i].coeff), h);
            chk("tbl_we_n", SRAM_we_n, 0);
            chk("tbl_addr", SRAM_address, vt[i].exp_addr);
            chk("tbl_data", $signed(SRAM_write_data), vt[i].exp_data);
            chk("tbl_finish", finish, (vt[i].n == TOTAL - 1) ? 1 : 0);
            pos = vt[i].n + 1;
        end
        cif.coeff_valid = 1'b0;

        // Reset in the middle of an image.
        restart(1'b0);
        for (int j = 0; j < 1000; j++) cycle(1'b1, 16'(j), h);
        chk("mid_we_n_before", SRAM_we_n, 0);
        #2 resetn = 1'b0;
        #1;
        chk("mid_we_n", SRAM_we_n, 1);
        chk("mid_ready", cif.coeff_ready, 0);
        chk("mid_addr", SRAM_address, 0);
        chk("mid_data", SRAM_write_data, 0);
        @(posedge clock); #1;
        chk("mid_we_n_held", SRAM_we_n, 1);
        resetn = 1'b1;
        cycle(1'b1, 16'd9, h);
        chk("mid_idle_we_n", SRAM_we_n, 1);
        do_start(1'b0);
        cycle(1'b1, 16'd1, h);
        chk("mid_restart_addr", SRAM_address, 76800);
        chk("mid_restart_data", $signed(SRAM_write_data), 8);
        chk("mid_restart_we_n", SRAM_we_n, 0);
        cif.coeff_valid = 1'b0;

        // Randomized full image with gaps, stray start pulses and q_sel churn.
        qs = 1'($urandom_range(0, 1));
        restart(qs);
        n = 0; wr_cnt = 0; fin_cnt = 0; done = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            v = ($urandom_range(0, 9) < 7);
            d = rand_coeff();
            start = ($urandom_range(0, 49) == 0);
            q_sel = 1'($urandom_range(0, 1));
            cycle(v, d, h);
            if (SRAM_we_n == 1'b0) wr_cnt++;
            if (finish) fin_cnt++;
            if (h) begin
                chk("rnd_we_n", SRAM_we_n, 0);
                chk("rnd_addr", SRAM_address, exp_addr(n));
                chk("rnd_data", $signed(SRAM_write_data), exp_val(d, n % 64, qs));
                chk("rnd_finish", finish, (n == TOTAL - 1) ? 1 : 0);
                n++;
                if (n == TOTAL) done = 1'b1;
            end else begin
                chk("rnd_gap_we_n", SRAM_we_n, 1);
                chk("rnd_gap_finish", finish, 0);
            end
        end
        start = 1'b0;
        chk("rnd_completed", done, 1);
        chk("rnd_done_ready", cif.coeff_ready, 0);
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 16'd5, h);
            if (SRAM_we_n == 1'b0) wr_cnt++;
            if (finish) fin_cnt++;
            chk("post_ready", cif.coeff_ready, 0);
            chk("post_we_n", SRAM_we_n, 1);
        end
        cif.coeff_valid = 1'b0;
        chk("rnd_write_count", wr_cnt, TOTAL);
        chk("rnd_finish_count", fin_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
